// File: rtl/pipe_ctrl.sv
// Central pipeline controller: per-stage valids, latch enables, flushes, PC redirect and trap settle FSM.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int XLEN       = 64,
  parameter int TRAP_HOLD  = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FE_FIRE,
  input  logic                  MEM_BUSY,
  input  logic                  BR_TAKEN,
  input  logic [XLEN-1:0]       BR_TARGET,
  input  logic                  TRAP_REQ,
  input  logic [XLEN-1:0]       TRAP_VEC,
  output logic [NUM_STAGES-1:0] STAGE_V,
  output logic [NUM_STAGES-1:0] STAGE_EN,
  output logic [NUM_STAGES-1:0] FLUSH,
  output logic                  PC_REDIRECT,
  output logic [XLEN-1:0]       PC_TARGET,
  output logic                  FE_HOLD,
  output logic [1:0]            CTRL_STATE,
  output logic [XLEN-1:0]       PERF_CYCLES,
  output logic [XLEN-1:0]       PERF_RETIRED,
  output logic [XLEN-1:0]       PERF_STALLS
);

  localparam int WB = NUM_STAGES - 1;
  localparam logic [1:0] ST_RUN        = 2'b00;
  localparam logic [1:0] ST_TRAP_FLUSH = 2'b01;
  localparam logic [1:0] ST_TRAP_WAIT  = 2'b10;
  localparam logic [3:0] HOLD_INIT     = 4'(TRAP_HOLD);

  logic [1:0]            state_q, state_d;
  logic [3:0]            hold_q, hold_d;
  logic [NUM_STAGES-1:0] stage_v_q, stage_v_d;
  logic                  redirect_q, redirect_d;
  logic [XLEN-1:0]       target_q, target_d;

  logic                  in_run, accept, trap_fire, br_fire, stall, fe_hold;
  logic [NUM_STAGES-1:0] flush, stage_en;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_run    = (state_q == ST_RUN);
    // A redirect in flight blocks new acceptance, so PC_REDIRECT never fires back-to-back.
    accept    = in_run & stage_v_q[WB] & ~redirect_q;
    trap_fire = accept & TRAP_REQ;
    br_fire   = accept & BR_TAKEN & ~TRAP_REQ;
    fe_hold   = ~in_run;

    flush = '0;
    if (br_fire)   flush = {1'b0, {(NUM_STAGES-1){1'b1}}};
    if (trap_fire) flush = '1;

    stall    = MEM_BUSY & ~(trap_fire | br_fire);
    stage_en = stall ? {1'b1, {(NUM_STAGES-1){1'b0}}} : '1;

    stage_v_d = stage_v_q;
    if (stage_en[0]) stage_v_d[0] = FE_FIRE & ~fe_hold & ~flush[0];
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (stage_en[i]) stage_v_d[i] = stage_v_q[i-1] & ~flush[i];
    end
    if (stall) stage_v_d[WB] = 1'b0;

    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_RUN:        if (trap_fire) state_d = ST_TRAP_FLUSH;
      ST_TRAP_FLUSH: begin
        hold_d  = HOLD_INIT;
        state_d = ST_TRAP_WAIT;
      end
      ST_TRAP_WAIT: begin
        hold_d = hold_q - 4'd1;
        if (hold_q <= 4'd1) begin
          hold_d  = 4'd0;
          state_d = ST_RUN;
        end
      end
      default:       state_d = ST_RUN;
    endcase

    redirect_d = trap_fire | br_fire;
    target_d   = target_q;
    if (trap_fire)    target_d = TRAP_VEC;
    else if (br_fire) target_d = BR_TARGET;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_RUN;
      hold_q     <= 4'd0;
      stage_v_q  <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      stage_v_q  <= stage_v_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  end

  assign STAGE_V     = stage_v_q;
  assign STAGE_EN    = stage_en;
  assign FLUSH       = flush;
  assign PC_REDIRECT = redirect_q;
  assign PC_TARGET   = target_q;
  assign FE_HOLD     = fe_hold;
  assign CTRL_STATE  = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [XLEN-1:0] cycles_q, cycles_d, retired_q, retired_d, stalls_q, stalls_d;

  always_comb begin
    cycles_d  = cycles_q + XLEN'(1);
    retired_d = retired_q + XLEN'(stage_v_q[WB] & ~trap_fire);
    stalls_d  = stalls_q + XLEN'(MEM_BUSY & in_run);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycles_q  <= '0;
      retired_q <= '0;
      stalls_q  <= '0;
    end else begin
      cycles_q  <= cycles_d;
      retired_q <= retired_d;
      stalls_q  <= stalls_d;
    end
  end

  assign PERF_CYCLES  = cycles_q;
  assign PERF_RETIRED = retired_q;
  assign PERF_STALLS  = stalls_q;
`else
  assign PERF_CYCLES  = '0;
  assign PERF_RETIRED = '0;
  assign PERF_STALLS  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized traffic against a cycle model.
module tb_pipe_ctrl;
  localparam int N  = 5;
  localparam int XL = 64;
  localparam int TH = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          FE_FIRE = 1'b0, MEM_BUSY = 1'b0, BR_TAKEN = 1'b0, TRAP_REQ = 1'b0;
  logic [XL-1:0] BR_TARGET = '0, TRAP_VEC = '0;
  logic [N-1:0]  STAGE_V, STAGE_EN, FLUSH;
  logic          PC_REDIRECT, FE_HOLD;
  logic [XL-1:0] PC_TARGET, PERF_CYCLES, PERF_RETIRED, PERF_STALLS;
  logic [1:0]    CTRL_STATE;

  pipe_ctrl #(.NUM_STAGES(N), .XLEN(XL), .TRAP_HOLD(TH)) dut (
    .CLK(CLK), .RESET(RESET), .FE_FIRE(FE_FIRE), .MEM_BUSY(MEM_BUSY),
    .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .TRAP_REQ(TRAP_REQ), .TRAP_VEC(TRAP_VEC),
    .STAGE_V(STAGE_V), .STAGE_EN(STAGE_EN), .FLUSH(FLUSH), .PC_REDIRECT(PC_REDIRECT),
    .PC_TARGET(PC_TARGET), .FE_HOLD(FE_HOLD), .CTRL_STATE(CTRL_STATE),
    .PERF_CYCLES(PERF_CYCLES), .PERF_RETIRED(PERF_RETIRED), .PERF_STALLS(PERF_STALLS)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 run, 1 trap flush, 2 trap wait.
  logic [N-1:0]  m_v;
  int            m_mode, m_wait;
  bit            m_redir;
  logic [XL-1:0] m_tgt, m_cyc, m_ret, m_stl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_v = '0; m_mode = 0; m_wait = 0; m_redir = 0;
    m_tgt = '0; m_cyc = '0; m_ret = '0; m_stl = '0;
  endtask

  task automatic check_regs();
    check("stage_v", 64'(STAGE_V), 64'(m_v));
    check("pc_redirect", 64'(PC_REDIRECT), 64'(m_redir));
    check("pc_target", PC_TARGET, m_tgt);
    check("ctrl_state", 64'(CTRL_STATE), 64'(m_mode));
    check("fe_hold", 64'(FE_HOLD), 64'(m_mode != 0));
`ifdef PIPE_CTRL_PERF_EN
    check("perf_cycles", PERF_CYCLES, m_cyc);
    check("perf_retired", PERF_RETIRED, m_ret);
    check("perf_stalls", PERF_STALLS, m_stl);
`else
    check("perf_cycles", PERF_CYCLES, 64'd0);
    check("perf_retired", PERF_RETIRED, 64'd0);
    check("perf_stalls", PERF_STALLS, 64'd0);
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit fe, input bit mb, input bit br, input logic [63:0] bt,
                      input bit tr, input logic [63:0] tv);
    bit hold, acc, tf, bf;
    logic [N-1:0] ef, ee;
    FE_FIRE = fe; MEM_BUSY = mb; BR_TAKEN = br; BR_TARGET = bt; TRAP_REQ = tr; TRAP_VEC = tv;
    #1;
    hold = (m_mode != 0);
    acc  = !hold && m_v[N-1] && !m_redir;
    tf   = acc && tr;
    bf   = acc && br && !tr;
    ef = '0;
    if (bf) ef = {N{1'b1}} >> 1;
    if (tf) ef = {N{1'b1}};
    ee = (mb && !tf && !bf) ? (N'(1) << (N-1)) : {N{1'b1}};
    check_regs();
    check("flush", 64'(FLUSH), 64'(ef));
    check("stage_en", 64'(STAGE_EN), 64'(ee));
    @(posedge CLK);
    m_cyc = m_cyc + 1;
    if (m_v[N-1] && !tf) m_ret = m_ret + 1;
    if (mb && m_mode == 0) m_stl = m_stl + 1;
    if (tf)      m_v = '0;
    else if (bf) m_v = {m_v[N-2], {(N-1){1'b0}}};
    else if (mb) m_v[N-1] = 1'b0;
    else         m_v = {m_v[N-2:0], fe && !hold};
    case (m_mode)
      0: if (tf) m_mode = 1;
      1: begin m_mode = 2; m_wait = TH; end
      default: begin
        m_wait--;
        if (m_wait == 0) m_mode = 0;
      end
    endcase
    m_redir = tf || bf;
    if (tf)      m_tgt = tv;
    else if (bf) m_tgt = bt;
    @(negedge CLK);
  endtask

  task automatic idle(input bit fe, input int n);
    for (int k = 0; k < n; k++) step(fe, 0, 0, 64'd0, 0, 64'd0);
  endtask

  initial begin
    model_reset();
    #1;
    check_regs();
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;

    // Fill walk, then a three-cycle memory stall.
    idle(1, 5);
    check("walk_full", 64'(STAGE_V), 64'h1f);
    check("walk_state", 64'(CTRL_STATE), 64'd0);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 64'd0, 0, 64'd0);
    check("stall_frozen", 64'(STAGE_V), 64'h0f);
    idle(1, 1);

    // Taken branch from a full pipe.
    step(1, 0, 1, 64'h8000_0100, 0, 64'd0);
    check("br_redirect", 64'(PC_REDIRECT), 64'd1);
    check("br_target", PC_TARGET, 64'h8000_0100);
    idle(1, 6);

    // Trap, then fetch attempts during the settle window.
    step(1, 0, 0, 64'd0, 1, 64'h8000_0004);
    check("trap_target", PC_TARGET, 64'h8000_0004);
    check("trap_state", 64'(CTRL_STATE), 64'd1);
    idle(1, 8);

    // Trap and branch together under a memory stall.
    step(1, 1, 1, 64'h1234, 1, 64'h8000_0040);
    check("both_target", PC_TARGET, 64'h8000_0040);
    idle(1, 8);

    // Reset asserted while waiting out a trap.
    step(1, 0, 0, 64'd0, 1, 64'h8000_0080);
    idle(1, 2);
    check("pre_reset_wait", 64'(CTRL_STATE), 64'd2);
    #2 RESET = 1'b1;
    #1;
    model_reset();
    check_regs();
    @(negedge CLK);
    RESET = 1'b0;
    idle(0, 1);
    idle(1, 6);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           {$urandom, $urandom}, $urandom_range(0, 11) == 0, {$urandom, $urandom});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Centralised, parametrised pipeline controller for the RISC-V core.
- Owns per-stage valid bits, latch enables, flushes and PC redirect, replacing the ad-hoc per-stage stall/br/trap wires.
- Sits beside fetch..writeback. Stage 0 = fetch, stage NUM_STAGES-1 = writeback, stage NUM_STAGES-2 = memory.
- Adds a trap-settle state machine that the current hand-wired stall nets lack.

Parameters:
NUM_STAGES, 5, pipeline depth (3..8)
XLEN, 64, PC/target width
TRAP_HOLD, 2, cycles fetch stays blocked after a trap redirect (1..15)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
FE_FIRE  input  1  fetch presents a new instruction this cycle
MEM_BUSY  input  1  memory stage requests stall
BR_TAKEN  input  1  writeback resolves taken branch/jump (qualified by STAGE_V[NUM_STAGES-1])
BR_TARGET  input  XLEN  branch/jump target
TRAP_REQ  input  1  writeback raises exception/interrupt (qualified by STAGE_V[NUM_STAGES-1])
TRAP_VEC  input  XLEN  trap target (mtvec-derived)
STAGE_V  output  NUM_STAGES  valid bit per stage latch
STAGE_EN  output  NUM_STAGES  latch load enable per stage (combinational)
FLUSH  output  NUM_STAGES  per-stage flush pulse (combinational)
PC_REDIRECT  output  1  one-cycle redirect strobe to fetch (registered)
PC_TARGET  output  XLEN  redirect address, valid with PC_REDIRECT
FE_HOLD  output  1  fetch must not issue
CTRL_STATE  output  2  00 RUN, 01 TRAP_FLUSH, 10 TRAP_WAIT
PERF_CYCLES, PERF_RETIRED, PERF_STALLS  output  XLEN each  performance counters (see Optional Feature)

Behaviour:
- Reset (async): STAGE_V=0, PC_REDIRECT=0, PC_TARGET=0, CTRL_STATE=RUN, hold counter=0, perf counters=0. FE_HOLD=0.
- Valid advance, when STAGE_EN[i]=1:
  - STAGE_V[0] <= FE_FIRE & ~FE_HOLD & ~FLUSH[0].
  - STAGE_V[i] <= STAGE_V[i-1] & ~FLUSH[i].
- Memory stall: MEM_BUSY=1 makes STAGE_EN[0..N-2]=0; those stages keep their contents. STAGE_EN[N-1]=1, so writeback gets a bubble (STAGE_V[N-1] <= 0).
- Branch, RUN state only: valid BR_TAKEN gives FLUSH[0..N-2]=1 for one cycle; all those valids clear next edge.
  - Next cycle: PC_REDIRECT=1, PC_TARGET=BR_TARGET.
  - Flush overrides MEM_BUSY: all STAGE_EN are forced to 1 that cycle.
- Trap, RUN state, valid TRAP_REQ:
  - Same flush as branch, and STAGE_V[N-1] also clears.
  - State -> TRAP_FLUSH.
  - TRAP_FLUSH (1 cycle): PC_REDIRECT=1, PC_TARGET=TRAP_VEC, FE_HOLD=1; load hold counter with TRAP_HOLD; -> TRAP_WAIT.
  - TRAP_WAIT: FE_HOLD=1, counter decrements each cycle; at 0 -> RUN. FE_HOLD drops the cycle RUN is entered.
- Simultaneous TRAP_REQ and BR_TAKEN: trap wins; branch ignored, target = TRAP_VEC.
- BR_TAKEN/TRAP_REQ outside RUN: ignored (pipeline empty by construction).
- STAGE_V[N-1]=0: BR_TAKEN/TRAP_REQ ignored.
- FE_FIRE while FE_HOLD: dropped, no valid inserted.
- RESET mid-trap: returns straight to RUN, all valids 0, no redirect issued.
- PC_REDIRECT is never high two consecutive cycles.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - PERF_CYCLES +1 every cycle out of reset.
  - PERF_RETIRED +1 each cycle STAGE_V[N-1]=1 with no trap.
  - PERF_STALLS +1 each cycle MEM_BUSY=1 in RUN.
  - All wrap modulo 2^XLEN.
- Undefined: the three outputs are tied to 0 and no counter flops are built.

Test Plan:
- Reset, then FE_FIRE=1 for 5 cycles, N=5 -> STAGE_V walks 00001,00011,00111,01111,11111; CTRL_STATE=00.
- Full pipe, MEM_BUSY=1 for 3 cycles -> STAGE_V[3:0] frozen, STAGE_V[4]=0 after first edge; PERF_STALLS=3 (with macro); resumes when MEM_BUSY=0.
- Full pipe, BR_TAKEN=1, BR_TARGET=0x80000100 -> same cycle FLUSH=01111; next cycle STAGE_V[3:0]=0, PC_REDIRECT=1, PC_TARGET=0x80000100; low the cycle after.
- Full pipe, TRAP_REQ=1, TRAP_VEC=0x80000004, TRAP_HOLD=2 -> STAGE_V=0; TRAP_FLUSH with PC_REDIRECT=1, PC_TARGET=0x80000004; 2 cycles TRAP_WAIT with FE_HOLD=1 and FE_FIRE dropped; then RUN.
- TRAP_REQ and BR_TAKEN same cycle, MEM_BUSY=1 -> trap path only, PC_TARGET=TRAP_VEC, stall overridden.
- RESET asserted mid TRAP_WAIT -> outputs immediately at reset values; after release, CTRL_STATE=00 and PC_REDIRECT=0.
